// File: rtl/sha256_digest_tx.sv
// sha256_digest_tx: captures a finished SHA-256 digest (H0..H7) on a load
// strobe and streams it out one word per handshake over valid/ready, H0 first.
// The configuration macro DIGEST_TX_BSWAP_EN byte-reverses every output word
// for little-endian hosts. Without the macro, words leave big-endian as captured.
module sha256_digest_tx #(
  parameter  int NWORDS = 8,
  parameter  int DW     = 32,
  localparam int IW     = $clog2(NWORDS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load,
  input  logic                 abort,
  input  logic [NWORDS*DW-1:0] digest_i,
  output logic                 busy,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [DW-1:0]        tx_data,
  output logic [IW-1:0]        tx_idx,
  output logic                 tx_last,
  output logic                 done,
  output logic                 load_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NWORDS - 1);

  state_t                 state_q,    state_d;
  logic [NWORDS*DW-1:0]   buf_q,      buf_d;
  logic [IW-1:0]          idx_q,      idx_d;
  logic [DW-1:0]          data_q,     data_d;
  logic                   valid_q,    valid_d;
  logic                   last_q,     last_d;
  logic                   done_q,     done_d;
  logic                   load_err_q, load_err_d;

  // Reverse the byte order of one word (byte 0 <-> byte N-1, and so on).
  function automatic logic [DW-1:0] byte_swap(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = {DW{1'b0}};
    for (int b = 0; b < DW / 8; b++) begin
      r[b*8 +: 8] = w[(DW/8 - 1 - b)*8 +: 8];
    end
    return r;
  endfunction

  // Word k of a captured digest; word 0 (H0) sits in the most significant slot.
  function automatic logic [DW-1:0] pick_word(input logic [NWORDS*DW-1:0] b,
                                              input logic [IW-1:0]        idx);
    int k;
    k = NWORDS - 1 - int'(idx);
    return b[k*DW +: DW];
  endfunction

  // Apply the optional host byte order to a word headed for tx_data.
  function automatic logic [DW-1:0] present(input logic [DW-1:0] w);
`ifdef DIGEST_TX_BSWAP_EN
    return byte_swap(w);
`else
    return w;
`endif
  endfunction

  // Next-state logic: capture, word advance, abort and error pulses.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    data_d     = data_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    if (abort) begin
      // Abort wins over load and handshake; the buffer is kept.
      state_d = IDLE;
      valid_d = 1'b0;
      idx_d   = IDX_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            // tx_data is loaded straight from digest_i so H0 shows next cycle.
            buf_d   = digest_i;
            idx_d   = IDX_ZERO;
            data_d  = present(pick_word(digest_i, IDX_ZERO));
            valid_d = 1'b1;
            state_d = SEND;
          end else begin
            valid_d = 1'b0;
          end
        end
        SEND: begin
          if (load) begin
            load_err_d = 1'b1;
          end else begin
            load_err_d = 1'b0;
          end
          if (valid_q && tx_ready) begin
            if (idx_q == IDX_LAST) begin
              state_d = IDLE;
              valid_d = 1'b0;
              idx_d   = IDX_ZERO;
              done_d  = 1'b1;
            end else begin
              idx_d  = idx_q + IDX_ONE;
              data_d = present(pick_word(buf_q, idx_q + IDX_ONE));
            end
          end else begin
            idx_d = idx_q;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          idx_d   = IDX_ZERO;
        end
      endcase
    end
    last_d = valid_d && (idx_d == IDX_LAST);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      buf_q      <= {(NWORDS*DW){1'b0}};
      idx_q      <= IDX_ZERO;
      data_q     <= {DW{1'b0}};
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign busy     = (state_q == SEND);
  assign tx_valid = valid_q;
  assign tx_data  = data_q;
  assign tx_idx   = idx_q;
  assign tx_last  = last_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Directed table-driven bench for sha256_digest_tx (NWORDS=8, DW=32).
// Expected words follow DIGEST_TX_BSWAP_EN when the bench is built with it.
module tb_sha256_digest_tx;

  logic         CLK = 1'b0;
  logic         RST;
  logic         load;
  logic         abort;
  logic [255:0] digest_i;
  logic         busy;
  logic         tx_valid;
  logic         tx_ready;
  logic [31:0]  tx_data;
  logic [2:0]   tx_idx;
  logic         tx_last;
  logic         done;
  logic         load_err;

  sha256_digest_tx #(.NWORDS(8), .DW(32)) dut (
    .CLK(CLK), .RST(RST), .load(load), .abort(abort), .digest_i(digest_i),
    .busy(busy), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_idx(tx_idx), .tx_last(tx_last), .done(done), .load_err(load_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ld;
    logic        ab;
    logic        dsel;
    logic        rdy;
    logic        ev;
    logic [2:0]  eidx;
    logic [31:0] edata;
    logic        elast;
    logic        edone;
    logic        elerr;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] abc[8];
  logic [255:0] abc_vec;
  logic [255:0] ones_vec;

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef DIGEST_TX_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic ld, input logic ab, input logic dsel, input logic rdy,
                     input logic ev, input int eidx, input logic [31:0] edata,
                     input logic elast, input logic edone, input logic elerr);
    vec_t v;
    v.ld = ld; v.ab = ab; v.dsel = dsel; v.rdy = rdy; v.ev = ev;
    v.eidx = 3'(eidx); v.edata = edata; v.elast = elast; v.edone = edone; v.elerr = elerr;
    vecs.push_back(v);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".busy"},     {31'd0, busy},     32'd0);
    check({tag, ".valid"},    {31'd0, tx_valid}, 32'd0);
    check({tag, ".data"},     tx_data,           32'd0);
    check({tag, ".idx"},      {29'd0, tx_idx},   32'd0);
    check({tag, ".last"},     {31'd0, tx_last},  32'd0);
    check({tag, ".done"},     {31'd0, done},     32'd0);
    check({tag, ".load_err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    abc[0] = 32'hba7816bf; abc[1] = 32'h8f01cfea; abc[2] = 32'h414140de; abc[3] = 32'h5dae2223;
    abc[4] = 32'hb00361a3; abc[5] = 32'h96177a9c; abc[6] = 32'hb410ff61; abc[7] = 32'hf20015ad;
    abc_vec  = {abc[0], abc[1], abc[2], abc[3], abc[4], abc[5], abc[6], abc[7]};
    ones_vec = {256{1'b1}};

    // Basic stream; digest_i switches to all-ones after capture (must not leak).
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, abc[0], 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, k, abc[k], (k == 7), 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 1'b0);
    // Backpressure 1,0,0 on words 1..3, then load while busy at idx 3.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, abc[0], 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, k, abc[k], 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, k, abc[k], 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, k, abc[k], 1'b0, 1'b0, 1'b0);
    end
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3, abc[3], 1'b0, 1'b0, 1'b1);
    for (int k = 4; k < 8; k++) add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, k, abc[k], (k == 7), 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7, abc[7], 1'b1, 1'b0, 1'b0);
    // Load on the final handshake: rejected with load_err.
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b1, 1'b1);
    // Load in the done cycle: accepted, H0 next cycle, no load_err.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, abc[0], 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 6; k++) add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, k, abc[k], 1'b0, 1'b0, 1'b0);
    // Abort at idx 5, then idle abort, then abort beating a load.
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Reset state.
    RST = 1'b1; load = 1'b0; abort = 1'b0; tx_ready = 1'b0; digest_i = abc_vec;
    #12;
    check_idle_zero("reset");
    step();
    RST = 1'b0;

    foreach (vecs[i]) begin
      load     = vecs[i].ld;
      abort    = vecs[i].ab;
      digest_i = vecs[i].dsel ? ones_vec : abc_vec;
      tx_ready = vecs[i].rdy;
      step();
      check($sformatf("v%0d.valid", i),    {31'd0, tx_valid}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d.busy", i),     {31'd0, busy},     {31'd0, vecs[i].ev});
      check($sformatf("v%0d.idx", i),      {29'd0, tx_idx},   {29'd0, vecs[i].eidx});
      check($sformatf("v%0d.last", i),     {31'd0, tx_last},  {31'd0, vecs[i].elast});
      check($sformatf("v%0d.done", i),     {31'd0, done},     {31'd0, vecs[i].edone});
      check($sformatf("v%0d.load_err", i), {31'd0, load_err}, {31'd0, vecs[i].elerr});
      if (vecs[i].ev) check($sformatf("v%0d.data", i), tx_data, exp_word(vecs[i].edata));
    end

    // Reset mid-stream at idx 2: outputs clear before the next edge.
    load = 1'b1; abort = 1'b0; digest_i = abc_vec; tx_ready = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    check("mid.idx_before", {29'd0, tx_idx}, 32'd2);
    check("mid.data_before", tx_data, exp_word(abc[2]));
    tx_ready = 1'b0;
    RST = 1'b1;
    #1;
    check_idle_zero("async_rst");
    step();
    RST = 1'b0;
    tx_ready = 1'b1;
    step();
    check("post_rst.done", {31'd0, done}, 32'd0);
    check("post_rst.valid", {31'd0, tx_valid}, 32'd0);
    load = 1'b1;
    step();
    load = 1'b0;
    check("reload.valid", {31'd0, tx_valid}, 32'd1);
    check("reload.data", tx_data, exp_word(abc[0]));
    step();
    check("reload.data1", tx_data, exp_word(abc[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_digest_tx.md
Name: sha256_digest_tx

Overview:
- Read-side counterpart of the SHA-256 working/hash registers.
- Captures the final 256-bit digest (H0..H7) in one cycle on a load strobe.
- Streams the digest out as 32-bit words over a valid/ready interface, H0 first.
- Sits between the compression core's hash registers and the host/bus output port.

Parameters:
- NWORDS, 8, number of 32-bit words per digest. Must be ≥2; index width is clog2(NWORDS).
- DW, 32, word width in bits. Capture bus width is NWORDS*DW.

Ports:
- CLK  input  1  clock. All state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- load  input  1  capture strobe; digest_i is sampled when load=1 and state is IDLE.
- abort  input  1  synchronous abort; returns to IDLE with no done pulse.
- digest_i  input  NWORDS*DW  digest; H0 = digest_i[255:224], H7 = digest_i[31:0].
- busy  output  1  high while state is SEND.
- tx_valid  output  1  output word valid.
- tx_ready  input  1  downstream accept.
- tx_data  output  DW  current output word.
- tx_idx  output  clog2(NWORDS)  index of the current word, 0..NWORDS-1.
- tx_last  output  1  high with the final word (tx_idx = NWORDS-1).
- done  output  1  one-cycle pulse after the final handshake.
- load_err  output  1  one-cycle pulse when load arrives while busy.

Behaviour:
- Reset (RST=1, asynchronous):
  - state = IDLE.
  - busy, tx_valid, tx_last, done, load_err = 0.
  - tx_data = 0, tx_idx = 0, capture buffer = 0.
- FSM states: IDLE, SEND.
- IDLE:
  - tx_valid = 0.
  - On load=1 (and abort=0): latch digest_i into the internal buffer, tx_idx <= 0, state <= SEND.
  - tx_valid and busy rise the cycle after load (latency 1).
  - tx_data = H0 in that same cycle.
- SEND:
  - tx_valid = 1.
  - tx_data = buffer word tx_idx, registered, not combinational from digest_i.
  - Handshake is valid & ready in the same cycle.
  - Handshake with tx_idx < NWORDS-1: tx_idx increments; the next word is presented the next cycle.
  - Handshake with tx_idx = NWORDS-1: state <= IDLE, tx_valid <= 0, done <= 1 for exactly one cycle.
  - tx_ready low: tx_data, tx_idx and tx_valid stay stable. There is no timeout, and valid is never withdrawn without a handshake (except by abort or reset).
- Throughput: tx_ready held high gives one word per cycle, so NWORDS cycles of tx_valid.
- tx_last = tx_valid & (tx_idx = NWORDS-1).
- Input changes: digest_i changes after capture have no effect on the words being transmitted.
- Simultaneous events:
  - load while in SEND: ignored (buffer not overwritten); load_err pulses one cycle.
  - load in the same cycle as the final handshake: state is still SEND, so the load is ignored and load_err pulses.
  - load in the cycle done is high: state is IDLE, so the load is accepted.
  - abort=1 in any state: state <= IDLE, tx_valid <= 0, tx_idx <= 0, no done. abort has priority over load and the handshake; the buffer is retained.
  - abort in IDLE: no effect.
- Reset mid-stream: immediate return to the reset values; the partial transfer is lost and no done is generated.

Optional Feature:
- Macro: DIGEST_TX_BSWAP_EN.
- Defined: each tx_data word is byte-reversed (byte 0 ↔ byte 3, byte 1 ↔ byte 2) for little-endian hosts. Word order and handshake are unchanged.
- Undefined: words are output big-endian exactly as captured.

Test Plan:
- Basic stream:
  - Stimulus: reset; load with digest = SHA-256("abc") (ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad); tx_ready=1.
  - Required: tx_valid rises 1 cycle after load; 8 consecutive words in that order; tx_last on f20015ad; done pulses the next cycle; busy=0 afterwards.
- Backpressure:
  - Stimulus: same load; tx_ready toggles 1,0,0,1,...
  - Required: tx_data/tx_idx hold while ready=0; all 8 words delivered exactly once, in order.
- Load while busy:
  - Stimulus: load a second digest (all 0xFFFFFFFF) at tx_idx=3.
  - Required: load_err pulses for 1 cycle; the remaining words are still from the first digest.
- Back-to-back:
  - Stimulus: load in the done cycle.
  - Required: accepted; new H0 presented the next cycle; no load_err.
- Abort and reset:
  - Stimulus: abort at tx_idx=5 → tx_valid=0, idx=0, no done. Then assert RST mid-stream at tx_idx=2.
  - Required: all outputs 0 immediately (asynchronous, before the next edge).
- Byte swap:
  - Stimulus: with DIGEST_TX_BSWAP_EN defined, load the "abc" digest.
  - Required: first word = bf1678ba, last word = ad1500f2.
